// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
// mem_access_unit_if : data-memory request/response channel (req/addr_ok/data_ok)
// Rev 1.0
// ============================================================================
interface mem_access_unit_if #(
  parameter int DW = 32
);
  logic          data_req;
  logic          data_wr;
  logic [1:0]    data_size;
  logic [DW-1:0] data_addr;
  logic [3:0]    data_wstrb;
  logic [DW-1:0] data_wdata;
  logic          data_addr_ok;
  logic          data_data_ok;
  logic [DW-1:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// mem_access_unit : MEM-stage data-memory access, store formatting, load align
// Optional MEM_LWLR_EN : LWL/LWR merge datapath.                      Rev 1.0
// ============================================================================
module mem_access_unit #(
  parameter int DW = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              MEM_Flush,
  input  logic              MEM_Wr,
  input  logic              EXE_Valid,
  input  logic              EXE_ExceptValid,
  input  logic [2:0]        EXE_LdOp,
  input  logic [1:0]        EXE_StOp,
  input  logic [DW-1:0]     EXE_ALUOut,
  input  logic [DW-1:0]     EXE_OutB,
  input  logic [DW-1:0]     EXE_Result,
  input  logic [4:0]        EXE_Dst,
  mem_access_unit_if.master bus,
  output logic              MEM_Valid,
  output logic [DW-1:0]     MEM_Result,
  output logic [4:0]        MEM_Dst,
  output logic              MEM_DCacheStall
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

  state_e        state_q;
  logic          valid_q;
  logic [2:0]    ldop_q;
  logic [1:0]    stop_q;
  logic [DW-1:0] addr_q;
  logic [DW-1:0] outb_q;
  logic [DW-1:0] result_q;
  logic [4:0]    dst_q;

  logic          stall_d;
  logic          capture_d;
  logic          new_memop_d;
  logic          is_load_d;
  logic [DW-1:0] rd_byte_sh_d;
  logic [DW-1:0] rd_half_sh_d;
  logic [DW-1:0] ld_data_d;

  assign stall_d     = (state_q == S_REQ) || (state_q == S_WAIT) || (state_q == S_DRAIN);
  assign capture_d   = MEM_Wr && !stall_d && !MEM_Flush;
  assign new_memop_d = EXE_Valid && !EXE_ExceptValid && ((EXE_LdOp != 3'd0) || (EXE_StOp != 2'd0));
  assign is_load_d   = (stop_q == 2'd0);

  assign MEM_Valid       = valid_q;
  assign MEM_Result      = result_q;
  assign MEM_Dst         = dst_q;
  assign MEM_DCacheStall = stall_d;

  // Request fields come straight from the stage registers, which cannot
  // change while stalled, so they stay stable until addr_ok.
  assign bus.data_req = (state_q == S_REQ);
  assign bus.data_wr  = !is_load_d;
  assign bus.data_addr = (is_load_d && (ldop_q >= 3'd5)) ? {addr_q[DW-1:2], 2'b00} : addr_q;

  always_comb begin
    bus.data_size  = 2'd0;
    bus.data_wstrb = 4'b0000;
    bus.data_wdata = '0;
    case (stop_q)
      2'd1: begin
        bus.data_size  = 2'd0;
        bus.data_wstrb = 4'b0001 << addr_q[1:0];
        bus.data_wdata = {4{outb_q[7:0]}};
      end
      2'd2: begin
        bus.data_size  = 2'd1;
        bus.data_wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
        bus.data_wdata = {2{outb_q[15:0]}};
      end
      2'd3: begin
        bus.data_size  = 2'd2;
        bus.data_wstrb = 4'b1111;
        bus.data_wdata = outb_q;
      end
      default: begin
        case (ldop_q)
          3'd1, 3'd2: bus.data_size = 2'd0;
          3'd3, 3'd4: bus.data_size = 2'd1;
          3'd0:       bus.data_size = 2'd0;
          default:    bus.data_size = 2'd2;
        endcase
      end
    endcase
  end

  assign rd_byte_sh_d = bus.data_rdata >> {addr_q[1:0], 3'b000};
  assign rd_half_sh_d = bus.data_rdata >> {addr_q[1], 4'b0000};

  always_comb begin
    ld_data_d = bus.data_rdata;
    case (ldop_q)
      3'd1: ld_data_d = {{24{rd_byte_sh_d[7]}}, rd_byte_sh_d[7:0]};
      3'd2: ld_data_d = {24'd0, rd_byte_sh_d[7:0]};
      3'd3: ld_data_d = {{16{rd_half_sh_d[15]}}, rd_half_sh_d[15:0]};
      3'd4: ld_data_d = {16'd0, rd_half_sh_d[15:0]};
`ifdef MEM_LWLR_EN
      // Little-endian LWL/LWR: memory bytes fill the register from the top (LWL)
      // or from the bottom (LWR); the remaining bytes keep the old rt value.
      3'd6: begin
        case (addr_q[1:0])
          2'd0:    ld_data_d = {bus.data_rdata[7:0],  outb_q[23:0]};
          2'd1:    ld_data_d = {bus.data_rdata[15:0], outb_q[15:0]};
          2'd2:    ld_data_d = {bus.data_rdata[23:0], outb_q[7:0]};
          default: ld_data_d = bus.data_rdata;
        endcase
      end
      3'd7: begin
        case (addr_q[1:0])
          2'd0:    ld_data_d = bus.data_rdata;
          2'd1:    ld_data_d = {outb_q[31:24], bus.data_rdata[31:8]};
          2'd2:    ld_data_d = {outb_q[31:16], bus.data_rdata[31:16]};
          default: ld_data_d = {outb_q[31:8],  bus.data_rdata[31:24]};
        endcase
      end
`endif
      default: ld_data_d = bus.data_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      valid_q  <= 1'b0;
      ldop_q   <= 3'd0;
      stop_q   <= 2'd0;
      addr_q   <= '0;
      outb_q   <= '0;
      result_q <= '0;
      dst_q    <= 5'd0;
    end else if (MEM_Flush) begin
      valid_q <= 1'b0;
      // An accepted request still owes one data_ok; swallow it in DRAIN.
      case (state_q)
        S_REQ:           state_q <= (bus.data_addr_ok && !bus.data_data_ok) ? S_DRAIN : S_IDLE;
        S_WAIT, S_DRAIN: state_q <= bus.data_data_ok ? S_IDLE : S_DRAIN;
        default:         state_q <= S_IDLE;
      endcase
    end else if (capture_d) begin
      valid_q  <= EXE_Valid;
      ldop_q   <= EXE_LdOp;
      stop_q   <= EXE_StOp;
      addr_q   <= EXE_ALUOut;
      outb_q   <= EXE_OutB;
      result_q <= EXE_Result;
      dst_q    <= EXE_Dst;
      state_q  <= new_memop_d ? S_REQ : S_IDLE;
    end else begin
      case (state_q)
        S_REQ: begin
          if (bus.data_addr_ok) begin
            if (bus.data_data_ok) begin
              state_q <= S_DONE;
              if (is_load_d) result_q <= ld_data_d;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (bus.data_data_ok) begin
            state_q <= S_DONE;
            if (is_load_d) result_q <= ld_data_d;
          end
        end
        S_DRAIN: begin
          if (bus.data_data_ok) state_q <= S_IDLE;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// tb_mem_access_unit : directed + randomized checks against a reference model
// Rev 1.0
// ============================================================================
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        MEM_Flush, MEM_Wr, EXE_Valid, EXE_ExceptValid;
  logic [2:0]  EXE_LdOp;
  logic [1:0]  EXE_StOp;
  logic [31:0] EXE_ALUOut, EXE_OutB, EXE_Result;
  logic [4:0]  EXE_Dst;
  logic        MEM_Valid, MEM_DCacheStall;
  logic [31:0] MEM_Result;
  logic [4:0]  MEM_Dst;

  int n_chk = 0;
  int n_err = 0;

  mem_access_unit_if #(.DW(32)) bus_if ();

  mem_access_unit #(.DW(32)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .MEM_Flush       (MEM_Flush),
    .MEM_Wr          (MEM_Wr),
    .EXE_Valid       (EXE_Valid),
    .EXE_ExceptValid (EXE_ExceptValid),
    .EXE_LdOp        (EXE_LdOp),
    .EXE_StOp        (EXE_StOp),
    .EXE_ALUOut      (EXE_ALUOut),
    .EXE_OutB        (EXE_OutB),
    .EXE_Result      (EXE_Result),
    .EXE_Dst         (EXE_Dst),
    .bus             (bus_if),
    .MEM_Valid       (MEM_Valid),
    .MEM_Result      (MEM_Result),
    .MEM_Dst         (MEM_Dst),
    .MEM_DCacheStall (MEM_DCacheStall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_load(input logic [2:0] ld, input logic [31:0] a,
                                             input logic [31:0] rd, input logic [31:0] rt);
    int          ofs;
    logic [31:0] r;
    logic [7:0]  m [4];
    logic [7:0]  o [4];
    ofs = int'(a % 32'd4);
    for (int i = 0; i < 4; i++) begin
      m[i] = 8'(rd >> (8 * i));
      o[i] = 8'(rt >> (8 * i));
    end
    case (ld)
      3'd1, 3'd2: begin
        r = (rd >> (8 * ofs)) % 32'd256;
        if (ld == 3'd1 && r >= 32'd128) r = r + 32'hFFFF_FF00;
      end
      3'd3, 3'd4: begin
        r = (rd >> (16 * (ofs / 2))) % 32'd65536;
        if (ld == 3'd3 && r >= 32'd32768) r = r + 32'hFFFF_0000;
      end
`ifdef MEM_LWLR_EN
      3'd6: begin
        for (int i = 0; i <= ofs; i++) o[3 - ofs + i] = m[i];
        r = {o[3], o[2], o[1], o[0]};
      end
      3'd7: begin
        for (int i = 0; i <= 3 - ofs; i++) o[i] = m[ofs + i];
        r = {o[3], o[2], o[1], o[0]};
      end
`endif
      default: r = rd;
    endcase
    return r;
  endfunction

  // Runs one instruction through the stage; entered and left at a negedge with the stage unstalled.
  task automatic run_op(input logic [2:0] ld, input logic [1:0] st, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] res, input logic [4:0] dst,
                        input logic v, input logic ex, input int aok, input int dok,
                        input logic [31:0] rd);
    logic        memop;
    int          nbytes, stalls;
    logic [1:0]  e_size;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata, e_addr, e_res;
    EXE_LdOp = ld; EXE_StOp = st; EXE_ALUOut = a; EXE_OutB = b; EXE_Result = res;
    EXE_Dst = dst; EXE_Valid = v; EXE_ExceptValid = ex; MEM_Wr = 1'b1;
    @(negedge clk);
    MEM_Wr = 1'b0;
    EXE_Valid = 1'b0;
    memop = v && !ex && (ld != 3'd0 || st != 2'd0);
    check("valid", MEM_Valid, v);
    check("dst", MEM_Dst, dst);
    if (!memop) begin
      check("nomem_req", bus_if.data_req, 0);
      check("nomem_stall", MEM_DCacheStall, 0);
      check("nomem_result", MEM_Result, res);
      return;
    end
    if (st != 2'd0) begin
      nbytes  = 1 << (st - 1);
      e_size  = 2'(st - 1);
      e_strb  = 4'((((1 << nbytes) - 1) << (a % 4)));
      e_wdata = (nbytes == 1) ? (b % 32'd256) * 32'h0101_0101 :
                (nbytes == 2) ? (b % 32'd65536) * 32'h0001_0001 : b;
      e_addr  = a;
      e_res   = res;
    end else begin
      e_size  = (ld <= 3'd2) ? 2'd0 : (ld <= 3'd4) ? 2'd1 : 2'd2;
      e_strb  = 4'd0;
      e_wdata = 32'd0;
      e_addr  = (ld >= 3'd5) ? a - (a % 32'd4) : a;
      e_res   = model_load(ld, a, rd, b);
    end
    stalls = 0;
    for (int k = 0; k <= aok; k++) begin
      check("req", bus_if.data_req, 1);
      check("addr", bus_if.data_addr, e_addr);
      check("wr", bus_if.data_wr, (st != 2'd0));
      check("size", bus_if.data_size, e_size);
      check("wstrb", bus_if.data_wstrb, e_strb);
      if (st != 2'd0) check("wdata", bus_if.data_wdata, e_wdata);
      if (MEM_DCacheStall) stalls++;
      bus_if.data_addr_ok = (k == aok);
      bus_if.data_data_ok = (k == aok) && (dok == 0);
      bus_if.data_rdata   = bus_if.data_data_ok ? rd : $urandom;
      @(negedge clk);
    end
    bus_if.data_addr_ok = 1'b0;
    bus_if.data_data_ok = 1'b0;
    for (int k = 1; k <= dok; k++) begin
      check("wait_noreq", bus_if.data_req, 0);
      if (MEM_DCacheStall) stalls++;
      bus_if.data_data_ok = (k == dok);
      bus_if.data_rdata   = bus_if.data_data_ok ? rd : $urandom;
      @(negedge clk);
    end
    bus_if.data_data_ok = 1'b0;
    check("stall_cycles", stalls, aok + 1 + dok);
    check("stall_end", MEM_DCacheStall, 0);
    check("result", MEM_Result, e_res);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0]  r_ld;
    logic [1:0]  r_st;
    logic [31:0] r_a;
    int          sel, align;

    resetn = 1'b0; MEM_Flush = 1'b0; MEM_Wr = 1'b0; EXE_Valid = 1'b0; EXE_ExceptValid = 1'b0;
    EXE_LdOp = 3'd0; EXE_StOp = 2'd0; EXE_ALUOut = 32'd0; EXE_OutB = 32'd0;
    EXE_Result = 32'd0; EXE_Dst = 5'd0;
    bus_if.data_addr_ok = 1'b0; bus_if.data_data_ok = 1'b0; bus_if.data_rdata = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_req", bus_if.data_req, 0);
    check("rst_wr", bus_if.data_wr, 0);
    check("rst_addr", bus_if.data_addr, 0);
    check("rst_wstrb", bus_if.data_wstrb, 0);
    check("rst_valid", MEM_Valid, 0);
    check("rst_result", MEM_Result, 0);
    check("rst_dst", MEM_Dst, 0);
    check("rst_stall", MEM_DCacheStall, 0);
    resetn = 1'b1;
    @(negedge clk);

    run_op(3'd1, 2'd0, 32'h0000_1003, 32'h0, 32'h1111_1111, 5'd3, 1, 0, 0, 0, 32'h8011_2233);
    check("lb_const", MEM_Result, 32'hFFFF_FF80);
    run_op(3'd0, 2'd2, 32'h0000_2002, 32'hAAAA_1234, 32'h2222_2222, 5'd4, 1, 0, 0, 1, 32'h0);
    check("sh_wstrb", bus_if.data_wstrb, 4'b1100);
    check("sh_wdata", bus_if.data_wdata, 32'h1234_1234);
    run_op(3'd5, 2'd0, 32'h0000_4008, 32'h0, 32'h3333_3333, 5'd6, 1, 0, 3, 2, 32'hCAFE_F00D);
    run_op(3'd6, 2'd0, 32'h0000_0001, 32'hAABB_CCDD, 32'h0, 5'd7, 1, 0, 0, 0, 32'h4433_2211);
`ifdef MEM_LWLR_EN
    check("lwl_const", MEM_Result, 32'h2211_CCDD);
`else
    check("lwl_const", MEM_Result, 32'h4433_2211);
`endif
    run_op(3'd0, 2'd3, 32'h0000_5000, 32'h1234_5678, 32'h4444_4444, 5'd8, 1, 1, 0, 0, 32'h0);
    run_op(3'd0, 2'd0, 32'h0, 32'h0, 32'h5A5A_A5A5, 5'd9, 1, 0, 0, 0, 32'h0);

    // LHU flushed while waiting for data: the late data_ok is swallowed
    EXE_LdOp = 3'd4; EXE_StOp = 2'd0; EXE_ALUOut = 32'h0000_3002; EXE_Result = 32'h5555_AAAA;
    EXE_Dst = 5'd10; EXE_Valid = 1'b1; EXE_ExceptValid = 1'b0; MEM_Wr = 1'b1;
    @(negedge clk);
    MEM_Wr = 1'b0;
    check("fw_req", bus_if.data_req, 1);
    bus_if.data_addr_ok = 1'b1;
    @(negedge clk);
    bus_if.data_addr_ok = 1'b0;
    check("fw_wait_stall", MEM_DCacheStall, 1);
    MEM_Flush = 1'b1;
    @(negedge clk);
    MEM_Flush = 1'b0;
    check("fw_drain_stall", MEM_DCacheStall, 1);
    check("fw_drain_valid", MEM_Valid, 0);
    MEM_Wr = 1'b1;
    @(negedge clk);
    MEM_Wr = 1'b0;
    check("fw_drain_hold", MEM_DCacheStall, 1);
    bus_if.data_data_ok = 1'b1; bus_if.data_rdata = 32'h9999_8888;
    @(negedge clk);
    bus_if.data_data_ok = 1'b0;
    check("fw_end_stall", MEM_DCacheStall, 0);
    check("fw_result", MEM_Result, 32'h5555_AAAA);
    check("fw_valid", MEM_Valid, 0);

    // Store flushed before addr_ok: request withdrawn
    EXE_LdOp = 3'd0; EXE_StOp = 2'd3; EXE_ALUOut = 32'h0000_6000; EXE_Valid = 1'b1; MEM_Wr = 1'b1;
    @(negedge clk);
    MEM_Wr = 1'b0;
    check("fr_req", bus_if.data_req, 1);
    MEM_Flush = 1'b1;
    @(negedge clk);
    MEM_Flush = 1'b0;
    check("fr_req_drop", bus_if.data_req, 0);
    check("fr_stall", MEM_DCacheStall, 0);
    check("fr_valid", MEM_Valid, 0);

    // Flush wins over a simultaneous load enable
    EXE_LdOp = 3'd5; EXE_StOp = 2'd0; EXE_ALUOut = 32'h0000_7000; EXE_Valid = 1'b1;
    MEM_Wr = 1'b1; MEM_Flush = 1'b1;
    @(negedge clk);
    MEM_Wr = 1'b0; MEM_Flush = 1'b0;
    check("fp_req", bus_if.data_req, 0);
    check("fp_stall", MEM_DCacheStall, 0);
    check("fp_valid", MEM_Valid, 0);

    repeat (80) begin
      sel  = int'($urandom % 3);
      r_ld = 3'd0;
      r_st = 2'd0;
      if (sel == 1) r_ld = 3'(1 + $urandom % 7);
      if (sel == 2) r_st = 2'(1 + $urandom % 3);
      align = (r_ld == 3'd3 || r_ld == 3'd4 || r_st == 2'd2) ? 2 :
              (r_ld == 3'd5 || r_st == 2'd3) ? 4 : 1;
      r_a = $urandom;
      r_a = r_a - (r_a % 32'(align));
      run_op(r_ld, r_st, r_a, $urandom, $urandom, 5'($urandom), ($urandom % 8) != 0,
             ($urandom % 8) == 0, int'($urandom % 4), int'($urandom % 3), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
